// File: rtl/bram_stream_reader.sv
// Streams a burst of consecutive RAM words out over a valid/ready port.
// Optional o_last output is compiled in when BRAM_READER_LAST_EN is defined.
//
// Ports:
//   clk, rst                       - clock, sync active-high reset
//   start, base_addr, length       - burst request (sampled in IDLE)
//   ram_rd_addr/_en, ram_rd_data   - 1-cycle-latency RAM read port
//   o_data, o_valid, i_ready       - output stream
//   busy, done                     - burst status / completion pulse
//   o_last (optional)              - marks final beat of a burst
module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2**16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic [AW-1:0]         ram_rd_addr,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  busy,
`ifdef BRAM_READER_LAST_EN
    output logic                  o_last,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = '0;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW:0]           rleft_q, rleft_d;
    logic [AW:0]           bleft_q, bleft_d;
    // hv: older beat parked in hold register.
    // rv: unconsumed beat sitting on ram_rd_data.
    logic                  hv_q, hv_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] hd_q, hd_d;
    logic                  done_q, done_d;

    logic rd_en;
    logic hs;
    logic pop_h;
    logic pop_r;

    always_comb begin
        // Issue only while fewer than two beats are held, so the
        // returning word always has a place to land.
        rd_en   = (state_q == READ) && !(hv_q && rv_q);
        o_valid = hv_q || rv_q;
        o_data  = hv_q ? hd_q : ram_rd_data;
        hs      = o_valid && i_ready;
        pop_h   = hs && hv_q;
        pop_r   = hs && !hv_q;

        state_d = state_q;
        addr_d  = addr_q;
        rleft_d = rleft_q;
        bleft_d = bleft_q;
        hv_d    = hv_q;
        rv_d    = rv_q;
        hd_d    = hd_q;
        done_d  = 1'b0;

        // A new read overwrites ram_rd_data; park the old word first.
        if (pop_h) begin
            hv_d = 1'b0;
        end else if (rd_en && rv_q && !pop_r) begin
            hv_d = 1'b1;
            hd_d = ram_rd_data;
        end

        if (rd_en) begin
            rv_d = 1'b1;
        end else if (pop_r) begin
            rv_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == CNT_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        addr_d  = base_addr;
                        rleft_d = length;
                        bleft_d = length;
                    end
                end
            end
            READ: begin
                if (rd_en) begin
                    addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
                    rleft_d = rleft_q - CNT_ONE;
                    if (rleft_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
                if (hs) begin
                    bleft_d = bleft_q - CNT_ONE;
                end
            end
            DRAIN: begin
                if (hs) begin
                    bleft_d = bleft_q - CNT_ONE;
                    if (bleft_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rleft_q <= '0;
            bleft_q <= '0;
            hv_q    <= 1'b0;
            rv_q    <= 1'b0;
            hd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rleft_q <= rleft_d;
            bleft_q <= bleft_d;
            hv_q    <= hv_d;
            rv_q    <= rv_d;
            hd_q    <= hd_d;
            done_q  <= done_d;
        end
    end

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = addr_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

`ifdef BRAM_READER_LAST_EN
    // The oldest buffered beat is the final one when one beat remains.
    assign o_last = o_valid && (bleft_q == CNT_ONE);
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader (DEPTH=16, RAM[i]=i).
// Cycle-by-cycle vector table plus reset and o_last sequences.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  base_addr;
    logic [4:0]  length;
    logic [3:0]  ram_rd_addr;
    logic        ram_rd_en;
    logic [31:0] ram_rd_data = '0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        busy;
    logic        done;
`ifdef BRAM_READER_LAST_EN
    logic        o_last;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_stream_reader #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_data(ram_rd_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .busy       (busy),
`ifdef BRAM_READER_LAST_EN
        .o_last     (o_last),
`endif
        .done       (done)
    );

    // RAM model: RAM[i] = i, one-cycle read latency, output held.
    always_ff @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= {28'd0, ram_rd_addr};
    end

    typedef struct {
        logic        st;
        logic [3:0]  base;
        logic [4:0]  len;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        eb;
        logic        edn;
        logic        een;
        logic [3:0]  ea;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic st, logic [3:0] b, logic [4:0] l,
                               logic r, logic ev, logic [31:0] ed,
                               logic eb, logic edn, logic een,
                               logic [3:0] ea);
        vec_t x;
        x.st = st; x.base = b; x.len = l; x.rdy = r;
        x.ev = ev; x.ed = ed; x.eb = eb; x.edn = edn;
        x.een = een; x.ea = ea;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] b,
                         input logic [4:0] l, input logic r);
        start = s; base_addr = b; length = l; i_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int nb;
    bit seen_done;
    logic [31:0] want;

    initial begin
        // A: base=10 len=4 ready=1, then start in the done cycle.
        vq.push_back(v(1,10,4,1, 0,0,  0,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  1,0, 1,10));
        vq.push_back(v(0,0,0,1,  1,10, 1,0, 1,11));
        vq.push_back(v(0,0,0,1,  1,11, 1,0, 1,12));
        vq.push_back(v(0,0,0,1,  1,12, 1,0, 1,13));
        vq.push_back(v(0,0,0,1,  1,13, 1,0, 0,0));
        vq.push_back(v(1,0,1,1,  0,0,  0,1, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  1,0, 1,0));
        vq.push_back(v(0,0,0,1,  1,0,  1,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,1, 0,0));
        // B: same burst, ready low cycles 3-6.
        vq.push_back(v(1,10,4,1, 0,0,  0,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  1,0, 1,10));
        vq.push_back(v(0,0,0,1,  1,10, 1,0, 1,11));
        vq.push_back(v(0,0,0,0,  1,11, 1,0, 1,12));
        vq.push_back(v(0,0,0,0,  1,11, 1,0, 0,0));
        vq.push_back(v(0,0,0,0,  1,11, 1,0, 0,0));
        vq.push_back(v(0,0,0,0,  1,11, 1,0, 0,0));
        vq.push_back(v(0,0,0,1,  1,11, 1,0, 0,0));
        vq.push_back(v(0,0,0,1,  1,12, 1,0, 1,13));
        vq.push_back(v(0,0,0,1,  1,13, 1,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,1, 0,0));
        // C: wrap, base=14 len=4.
        vq.push_back(v(1,14,4,1, 0,0,  0,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  1,0, 1,14));
        vq.push_back(v(0,0,0,1,  1,14, 1,0, 1,15));
        vq.push_back(v(0,0,0,1,  1,15, 1,0, 1,0));
        vq.push_back(v(0,0,0,1,  1,0,  1,0, 1,1));
        vq.push_back(v(0,0,0,1,  1,1,  1,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,1, 0,0));
        // D: length=0, then start while busy is ignored.
        vq.push_back(v(1,5,0,1,  0,0,  0,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,1, 0,0));
        vq.push_back(v(1,2,2,1,  0,0,  0,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  1,0, 1,2));
        vq.push_back(v(1,9,3,1,  1,2,  1,0, 1,3));
        vq.push_back(v(0,0,0,1,  1,3,  1,0, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,1, 0,0));
        vq.push_back(v(0,0,0,1,  0,0,  0,0, 0,0));

        rst = 1'b1;
        drive(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", ram_rd_en, 0);
        chk("rst_addr", ram_rd_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].base, vq[i].len, vq[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), o_valid, vq[i].ev);
            chk($sformatf("v%0d_busy", i), busy, vq[i].eb);
            chk($sformatf("v%0d_done", i), done, vq[i].edn);
            chk($sformatf("v%0d_en", i), ram_rd_en, vq[i].een);
            if (vq[i].een)
                chk($sformatf("v%0d_addr", i), ram_rd_addr, vq[i].ea);
            if (vq[i].ev)
                chk($sformatf("v%0d_data", i), o_data, vq[i].ed);
            next_cycle();
        end

        // Reset during beat 2 of a length-8 burst.
        drive(1, 3, 8, 1);
        next_cycle();
        drive(0, 0, 0, 1);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_beat2", o_data, 4);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", o_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_en", ram_rd_en, 0);
        chk("mrst_addr", ram_rd_addr, 0);
        next_cycle();
        @(negedge clk);
        chk("mrst_idle_valid", o_valid, 0);
        next_cycle();
        drive(1, 0, 2, 1);
        nb = 0;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_valid && i_ready) begin
                want = nb;
                chk($sformatf("post_rst_beat%0d", nb), o_data, want);
                nb++;
            end
            if (done) seen_done = 1;
            next_cycle();
            drive(0, 0, 0, 1);
        end
        chk("post_rst_count", nb, 2);
        chk("post_rst_done", seen_done, 1);

`ifdef BRAM_READER_LAST_EN
        drive(1, 5, 3, 1);
        @(negedge clk);
        chk("last3_c0", o_last, 0);
        next_cycle();
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("last3_c1", o_last, 0);
        next_cycle();
        @(negedge clk);
        chk("last3_b1", o_last, 0);
        chk("last3_d1", o_data, 5);
        next_cycle();
        @(negedge clk);
        chk("last3_b2", o_last, 0);
        next_cycle();
        @(negedge clk);
        chk("last3_b3", o_last, 1);
        chk("last3_d3", o_data, 7);
        next_cycle();
        @(negedge clk);
        chk("last3_after", o_last, 0);
        next_cycle();
        drive(1, 9, 1, 1);
        next_cycle();
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("last1_c1", o_last, 0);
        next_cycle();
        @(negedge clk);
        chk("last1_valid", o_valid, 1);
        chk("last1_b1", o_last, 1);
        next_cycle();
        @(negedge clk);
        chk("last1_after", o_last, 0);
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the RAM word and stream data.
REQ-002 SHALL have parameter DEPTH, default 2**16, the RAM word count; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to stream a burst.
REQ-006 SHALL have port base_addr  input  AW  first RAM word of the burst, sampled with start.
REQ-007 SHALL have port length  input  AW+1  burst beat count, 0..DEPTH, sampled with start.
REQ-008 SHALL have port ram_rd_addr  output  AW  RAM read address.
REQ-009 SHALL have port ram_rd_en  output  1  RAM read enable.
REQ-010 SHALL have port ram_rd_data  input  DATA_WIDTH  RAM read data; valid the cycle after ram_rd_en; held while ram_rd_en is low.
REQ-011 SHALL have port o_data  output  DATA_WIDTH  stream data.
REQ-012 SHALL have port o_valid  output  1  stream valid.
REQ-013 SHALL have port i_ready  input  1  stream ready from downstream.
REQ-014 SHALL have port busy  output  1  burst in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 SHALL use states IDLE (busy=0), READ (reads remaining), DRAIN (all reads issued, beats outstanding).
REQ-017 SHALL accept start only in IDLE; start while busy is ignored with no side effect.
REQ-018 With start in cycle 0 and length>0, SHALL assert ram_rd_en with ram_rd_addr=base_addr in cycle 1 and o_valid with o_data=RAM[base_addr] in cycle 2; busy high from cycle 1.
REQ-019 SHALL increment ram_rd_addr by 1 per issued read, wrapping from DEPTH-1 to 0.
REQ-020 SHALL issue exactly length reads and deliver exactly length beats in address order with no loss or duplication.
REQ-021 SHALL transfer a beat only in a cycle where o_valid and i_ready are both high; o_data and o_valid SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022 SHALL buffer at most 2 beats (held plus in flight) and assert ram_rd_en only when the returning word has guaranteed storage; ram_rd_en SHALL be a registered-state function, never combinational from i_ready.
REQ-023 With i_ready held high SHALL sustain one beat per cycle after the first beat.
REQ-024 SHALL move READ->DRAIN after the last read is issued and DRAIN->IDLE on the final beat handshake.
REQ-025 SHALL pulse done for one cycle in the cycle after the final beat handshake, with busy=0 that cycle; a new start SHALL be accepted in that cycle.
REQ-026 With length=0 SHALL issue no reads, assert no o_valid, and pulse done in cycle 1 with busy=0.
REQ-027 With length=DEPTH SHALL read every word once, starting at base_addr and wrapping.

Reset
REQ-028 In a cycle with rst high SHALL go to IDLE; busy, done, o_valid, ram_rd_en SHALL be 0 and ram_rd_addr 0 after that edge.
REQ-029 Reset mid-burst SHALL discard all buffered and in-flight data; no o_valid until a new start.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 Macro BRAM_READER_LAST_EN, when defined, SHALL add output o_last (1 bit) asserted with o_valid on the final beat of each burst only, reset 0.
REQ-032 Without BRAM_READER_LAST_EN the o_last port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 RAM[i]=i; start base=10 length=4, i_ready=1 -> o_valid cycles 2-5 with data 10,11,12,13; done in cycle 6.
REQ-034 Same burst, i_ready low cycles 3-6 -> data 11 held stable cycles 3-6; no beat lost; ram_rd_en never with 2 beats outstanding.
REQ-035 DEPTH=16, base=14 length=4 -> addresses 14,15,0,1 and data in that order.
REQ-036 length=0 -> no ram_rd_en, no o_valid, done cycle 1; start during a busy burst -> ignored.
REQ-037 rst during beat 2 of length=8 -> outputs 0 next cycle; new burst base=0 length=2 -> exactly 2 correct beats.
REQ-038 BRAM_READER_LAST_EN defined, length=3 -> o_last high only with the third beat; length=1 -> high with the only beat.
